// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared FFT constants and result-writeback state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_SIZE    = 16;
    localparam int FFT_SAMPLES = 2048;
    localparam int FFT_LINE_W  = 512;
    localparam int FFT_ADDR_W  = 64;
    localparam int FFT_LINES   = FFT_SAMPLES * FFT_SIZE / FFT_LINE_W;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_FETCH = 2'd1,
        WB_SEND  = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_wb_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fft_wb_perf_cnt
// Description : Saturating event counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_wb_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_count <= '0;
        end else if (i_en && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule : fft_wb_perf_cnt
`default_nettype wire

// File: rtl/fft_result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : fft_result_writeback
// Description : Drains the FFT output buffer line by line to the host write
//               channel. Optional stall counter under FFT_WB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_result_writeback
    import fft_pkg::*;
#(
    parameter int SIZE    = FFT_SIZE,
    parameter int SAMPLES = FFT_SAMPLES,
    parameter int LINE_W  = FFT_LINE_W,
    parameter int ADDR_W  = FFT_ADDR_W,
    localparam int LINES      = SAMPLES * SIZE / LINE_W,
    localparam int IDX_W      = $clog2(LINES),
    localparam int LINE_BYTES = LINE_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  rd_index,
    input  logic [LINE_W-1:0] rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LINE_W-1:0] wr_data,
    output logic              wr_last
`ifdef FFT_WB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int              OFS_W       = $clog2(LINE_BYTES);
    localparam logic [IDX_W-1:0] c_last_line = IDX_W'(LINES - 1);

    wb_state_t          r_state;
    wb_state_t          w_state_nxt;
    logic [IDX_W-1:0]   r_line;
    logic [ADDR_W-1:0]  r_base;
    logic               w_accept;
    logic               w_handshake;

    assign w_accept    = (r_state == WB_IDLE) && start;
    assign w_handshake = (r_state == WB_SEND) && wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE:  if (start) w_state_nxt = WB_FETCH;
            WB_FETCH: w_state_nxt = WB_SEND;
            WB_SEND:  if (w_handshake) w_state_nxt = wr_last ? WB_DONE : WB_FETCH;
            WB_DONE:  w_state_nxt = WB_IDLE;
            default:  w_state_nxt = WB_IDLE;
        endcase
    end

    // Base is forced onto a line boundary; line offsets wrap modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line   <= '0;
            r_base   <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base <= base_addr & ~ADDR_W'(LINE_BYTES - 1);
                r_line <= '0;
            end
            if (r_state == WB_FETCH) begin
                wr_data  <= rd_data;
                wr_addr  <= r_base + (ADDR_W'(r_line) << OFS_W);
                wr_last  <= (r_line == c_last_line);
                wr_valid <= 1'b1;
            end
            if (w_handshake) begin
                wr_valid <= 1'b0;
                if (!wr_last) begin
                    r_line <= r_line + IDX_W'(1);
                end
            end
        end
    end

    assign rd_index = r_line;
    assign busy     = (r_state != WB_IDLE);
    assign done     = (r_state == WB_DONE);

`ifdef FFT_WB_PERF_CNT_EN
    fft_wb_perf_cnt #(
        .WIDTH (32)
    ) u_perf_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_en    (wr_valid && !wr_ready),
        .o_count (stall_cycles)
    );
`endif

endmodule : fft_result_writeback
`default_nettype wire

// File: tb/tb_fft_result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_result_writeback
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_result_writeback;

    localparam int LINES = 64;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
        logic         last;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  base_addr;
    logic         busy;
    logic         done;
    logic [5:0]   rd_index;
    logic [511:0] rd_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_last;
`ifdef FFT_WB_PERF_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    logic [511:0] mem [LINES];
    wr_t          exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int dones = 0;
    int stall_model = 0;
    int stall_left = 0;
    int stall_line = -1;
    bit rand_ready = 1'b0;
    bit pend = 1'b0;
    logic [63:0]  paddr;
    logic [511:0] pdata;
    logic [63:0]  first_addr;
    logic [63:0]  last_addr;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_index];

    fft_result_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_last      (wr_last)
`ifdef FFT_WB_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host-side ready driver: optional stall window on one line, else random or high.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && wr_valid && n_writes == stall_line) begin
            wr_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            wr_ready = ($urandom_range(0, 2) != 0);
        end else begin
            wr_ready = 1'b1;
        end
    end

    // Monitor: handshakes resolve at the next posedge using the values seen here.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (done) dones++;
            if (pend) begin
                chk("hold_valid", wr_valid, 1'b1);
                chk("hold_addr", wr_addr, paddr);
                chk("hold_data", wr_data, pdata);
            end
            pend = 1'b0;
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_queue_size", exp_q.size(), 1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("wr_last", wr_last, e.last);
                end
                if (n_writes == 0) first_addr = wr_addr;
                last_addr = wr_addr;
                n_writes++;
            end else if (wr_valid) begin
                pend  = 1'b1;
                paddr = wr_addr;
                pdata = wr_data;
                stall_model++;
            end
        end
    end

    task automatic fill_pattern();
        for (int k = 0; k < LINES; k++) begin
            logic [15:0] v;
            v = 16'(k);
            mem[k] = {32{v}};
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < LINES; k++) begin
            for (int w = 0; w < 16; w++) mem[k][w*32 +: 32] = $urandom;
        end
    endtask

    task automatic drain(input logic [63:0] base, input int exp_cyc,
                         input int inject_at, input int abort_at);
        int n;
        int first_v;
        bit injected;
        logic [63:0] aligned;
        aligned = base & ~64'h3F;
        exp_q.delete();
        for (int k = 0; k < LINES; k++) begin
            wr_t e;
            e.addr = aligned + 64'(k) * 64'd64;
            e.data = mem[k];
            e.last = (k == LINES - 1);
            exp_q.push_back(e);
        end
        n_writes = 0; dones = 0; stall_model = 0;
        first_v = -1; injected = 1'b0;
        base_addr = base;
        start = 1'b1;
        tick();
        base_addr = {$urandom, $urandom};
        n = 1;
        while (!done && n < 2000) begin
            start = 1'b0;
            if (n == 1) chk("busy_after_start", busy, 1'b1);
            if (wr_valid && first_v < 0) begin
                first_v = n;
                chk("first_valid_cycle", n, 2);
            end
            if (inject_at >= 0 && !injected && n_writes == inject_at) begin
                injected  = 1'b1;
                start     = 1'b1;
                base_addr = 64'h9000;
            end
            if (abort_at >= 0 && n_writes == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_wr_valid", wr_valid, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                exp_q.delete();
                stall_model = 0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    chk("rst_no_done", done, 1'b0);
                end
                chk("rst_done_pulses", dones, 0);
`ifdef FFT_WB_PERF_CNT_EN
                chk("rst_stall_cycles", stall_cycles, stall_model);
`endif
                return;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        if (exp_cyc >= 0) chk("done_cycle", n, exp_cyc);
        tick();
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        tick();
        chk("done_pulses", dones, 1);
        chk("writes_total", n_writes, LINES);
        chk("queue_empty", exp_q.size(), 0);
`ifdef FFT_WB_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, stall_model);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0;
        wr_ready = 1'b0;
        fill_pattern();
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_wr_valid", wr_valid, 1'b0);
        chk("reset_wr_last", wr_last, 1'b0);
        chk("reset_wr_addr", wr_addr, 64'h0);
        chk("reset_wr_data", wr_data, 512'h0);
        chk("reset_rd_index", rd_index, 6'd0);
`ifdef FFT_WB_PERF_CNT_EN
        chk("reset_stall_cycles", stall_cycles, 32'd0);
`endif
        // start asserted together with rst must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_beats_start", busy, 1'b0);
        rst = 1'b0;
        tick();

        drain(64'h1000, 2 * LINES + 1, -1, -1);
        chk("basic_first_addr", first_addr, 64'h1000);
        chk("basic_last_addr", last_addr, 64'h1FC0);

        stall_line = 3; stall_left = 5;
        drain(64'h1000, 2 * LINES + 1 + 5, -1, -1);
`ifdef FFT_WB_PERF_CNT_EN
        chk("backpressure_stalls", stall_cycles, 32'd5);
`endif
        stall_line = -1;

        drain(64'h1000, 2 * LINES + 1, 10, -1);
        chk("busy_start_last_addr", last_addr, 64'h1FC0);

        fill_random();
        drain(64'h1000, -1, -1, 20);
        drain(64'h2000, 2 * LINES + 1, -1, -1);
        chk("after_rst_first_addr", first_addr, 64'h2000);

        drain(64'h103F, 2 * LINES + 1, -1, -1);
        chk("misaligned_first_addr", first_addr, 64'h1000);
        chk("misaligned_last_addr", last_addr, 64'h1FC0);

        fill_random();
        drain(64'hFFFF_FFFF_FFFF_FFD5, 2 * LINES + 1, -1, -1);
        chk("wrap_last_addr", last_addr, 64'h0000_0000_0000_0F80);

        rand_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            drain({$urandom, $urandom}, -1, -1, -1);
        end
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fft_result_writeback
`default_nettype wire
